lfsr_decrypt_engine: RTL and testbench

LFSR_DECRYPT_ENGINE -- requirements
Module: lfsr_decrypt_engine

---
 rtl/lfsr_decrypt_engine.sv | 138 +++++++++++++
 tb/tb_lfsr_decrypt_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_decrypt_engine.sv
// rtl/lfsr_decrypt_engine.sv - detects the 7-bit LFSR tap pattern from a space pre-pad, then decrypts 64 bytes
module lfsr_decrypt_engine (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [3:0] ptrn_idx,
  output logic       no_match,
  output logic       parity_err
);

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECRYPT, DONE} state_t;

  state_t     state, state_nx;
  logic [5:0] cnt;
  logic [3:0] p;
  logic [6:0] lfsr;
  logic [6:0] buffer [10];
  logic [6:0] srch_s;
  logic       match;
  logic       seed_zero;
  logic       byte_bad;

  function automatic logic [6:0] tap_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      4'd8:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  // The pre-pad is all spaces, so buffer[0..9] are raw LFSR states; replay pattern p against them.
  always_comb begin
    match  = 1'b1;
    srch_s = buffer[0];
    for (int j = 1; j < 10; j++) begin
      srch_s = lfsr_step(srch_s, tap_of(p));
      if (srch_s != buffer[j]) match = 1'b0;
    end
  end

  assign seed_zero = (buffer[0] == 7'd0);
  assign byte_bad  = mem_rd_data[7] != ^mem_rd_data[6:0];

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    wr_en    = 1'b0;
    mem_addr = 8'd0;
    wr_addr  = 8'd0;
    wr_data  = 8'd0;
    case (state)
      IDLE: if (!req) state_nx = LOAD;
      LOAD: begin
        mem_addr = 8'd64 + {2'b00, cnt};
        if (cnt == 6'd9) state_nx = seed_zero ? DONE : SEARCH;
      end
      SEARCH: begin
        if (match) state_nx = DECRYPT;
        else if (p == 4'd8) state_nx = DONE;
      end
      DECRYPT: begin
        mem_addr = 8'd64 + {2'b00, cnt};
        wr_en    = 1'b1;
        wr_addr  = {2'b00, cnt};
        wr_data  = {1'b0, mem_rd_data[6:0] ^ lfsr} + 8'h20;
        if (cnt == 6'd63) state_nx = DONE;
      end
      DONE: begin
        ack = 1'b1;
        if (req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      p          <= 4'd0;
      lfsr       <= 7'd0;
      ptrn_idx   <= 4'd15;
      no_match   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (!req) begin
          cnt        <= 6'd0;
          ptrn_idx   <= 4'd15;
          no_match   <= 1'b0;
          parity_err <= 1'b0;
        end
        LOAD: begin
          buffer[cnt[3:0]] <= mem_rd_data[6:0];
          cnt              <= cnt + 6'd1;
          p                <= 4'd0;
          if (cnt == 6'd9 && seed_zero) no_match <= 1'b1;
        end
        SEARCH: begin
          if (match) begin
            ptrn_idx <= p;
            lfsr     <= buffer[0];
            cnt      <= 6'd0;
          end else if (p == 4'd8) begin
            no_match <= 1'b1;
          end else begin
            p <= p + 4'd1;
          end
        end
        DECRYPT: begin
          lfsr <= lfsr_step(lfsr, tap_of(ptrn_idx));
          cnt  <= cnt + 6'd1;
          if (byte_bad) parity_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// tb/tb_lfsr_decrypt_engine.sv - self-checking bench for lfsr_decrypt_engine
module tb_lfsr_decrypt_engine;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       req = 1'b1;
  logic       ack, wr_en, no_match, parity_err;
  logic [7:0] mem_addr, mem_rd_data, wr_addr, wr_data;
  logic [3:0] ptrn_idx;

  logic [7:0] mem [256];
  logic [7:0] plain [64];
  logic [7:0] exp_out [64];
  int         tap_tbl [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};
  int         exp_p, exp_lat, cyc, first_ack, wr_count, n_pass, n_total, dec0;
  bit         exp_nm, exp_pe, active, in_dec;
  string      msg = "Mr. Watson, come here. I want to see you.";

  lfsr_decrypt_engine dut (
    .clk(clk), .init(init), .req(req), .ack(ack),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ptrn_idx(ptrn_idx), .no_match(no_match), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) if (wr_en) begin
    mem[wr_addr] <= wr_data;
    wr_count++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int step(input int s, input int t);
    return ((s << 1) & 'h7f) | ($countones(s & t) & 1);
  endfunction

  // Encrypt plain[] into memory 64..127 with even parity in bit 7.
  task automatic encode(input int taps, input int seed);
    int s, pay;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      pay = ((int'(plain[i]) - 32) & 'h7f) ^ s;
      mem[64+i] = 8'((($countones(pay) & 1) << 7) | pay);
      s = step(s, taps);
    end
  endtask

  task automatic build_model();
    int  seed, s;
    bit  ok;
    seed   = int'(mem[64]) & 'h7f;
    exp_p  = 15;
    exp_nm = 1'b1;
    exp_pe = 1'b0;
    if (seed != 0)
      for (int k = 0; k < 9; k++) if (exp_p == 15) begin
        s  = seed;
        ok = 1'b1;
        for (int j = 1; j < 10; j++) begin
          s = step(s, tap_tbl[k]);
          if (s != (int'(mem[64+j]) & 'h7f)) ok = 1'b0;
        end
        if (ok) begin
          exp_p  = k;
          exp_nm = 1'b0;
        end
      end
    exp_lat = exp_nm ? ((seed == 0) ? 10 : 19) : 10 + exp_p + 1 + 64;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      exp_out[i] = 8'((((int'(mem[64+i]) & 'h7f) ^ s) + 32) & 'hff);
      if (!exp_nm && ($countones(mem[64+i]) % 2 == 1)) exp_pe = 1'b1;
      s = step(s, exp_nm ? 0 : tap_tbl[exp_p]);
    end
  endtask

  always @(negedge clk) if (active) begin
    dec0   = 11 + exp_p;
    in_dec = !exp_nm && cyc >= dec0 && cyc < dec0 + 64;
    chk("ack", int'(ack), int'(cyc >= exp_lat));
    chk("wr_en", int'(wr_en), int'(in_dec));
    if (cyc < 10) chk("load_addr", int'(mem_addr), 64 + cyc);
    if (in_dec) begin
      chk("dec_addr", int'(mem_addr), 64 + cyc - dec0);
      chk("wr_addr", int'(wr_addr), cyc - dec0);
      chk("wr_data", int'(wr_data), int'(exp_out[cyc-dec0]));
    end
    if (ack && first_ack < 0) first_ack = cyc;
  end

  function automatic int count_bad_out();
    int n = 0;
    for (int i = 0; i < 64; i++) if (mem[i] != exp_out[i]) n++;
    return n;
  endfunction

  task automatic run(input string name, input int abort_cyc);
    build_model();
    for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
    wr_count  = 0;
    first_ack = -1;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    cyc    = 0;
    active = 1'b1;
    while (cyc < exp_lat + 2) begin
      if (cyc == abort_cyc) begin
        @(negedge clk);
        #1;
        active = 1'b0;
        init   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_ack"}, int'(ack), 0);
        chk({name, "_wr_en"}, int'(wr_en), 0);
        chk({name, "_mem_addr"}, int'(mem_addr), 0);
        chk({name, "_ptrn"}, int'(ptrn_idx), 15);
        chk({name, "_no_match"}, int'(no_match), 0);
        chk({name, "_parity"}, int'(parity_err), 0);
        init = 1'b0;
        req  = 1'b1;
        return;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    active = 1'b0;
    req    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_ack_release"}, int'(ack), 0);
    chk({name, "_ptrn"}, int'(ptrn_idx), exp_p);
    chk({name, "_no_match"}, int'(no_match), int'(exp_nm));
    chk({name, "_parity"}, int'(parity_err), int'(exp_pe));
    chk({name, "_first_ack"}, first_ack, exp_lat);
    chk({name, "_wr_count"}, wr_count, exp_nm ? 0 : 64);
    if (!exp_nm) chk({name, "_out_bad"}, count_bad_out(), 0);
  endtask

  function automatic int count_not_space();
    int n = 0;
    for (int i = 0; i < 64; i++) if (mem[i] != 8'h20) n++;
    return n;
  endfunction

  initial begin
    int seed2, bad;
    n_pass  = 0;
    n_total = 0;
    active  = 1'b0;
    cyc     = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) plain[i] = 8'h20;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_ptrn", int'(ptrn_idx), 15);
    chk("rst_no_match", int'(no_match), 0);
    chk("rst_parity", int'(parity_err), 0);

    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_hold_ack", int'(ack), 0);
    chk("init_hold_addr", int'(mem_addr), 0);
    req  = 1'b1;
    init = 1'b0;

    encode('h60, 1);
    chk("enc_e0", int'(mem[64]), 'h81);
    chk("enc_e6", int'(mem[70]), 'h41);
    run("spaces", -1);
    chk("spaces_lit_ptrn", int'(ptrn_idx), 0);
    chk("spaces_lit_ack", first_ack, 75);
    chk("spaces_lit_text", count_not_space(), 0);
    chk("spaces_lit_parity", int'(parity_err), 0);

    for (int j = 0; j < msg.len(); j++) plain[10+j] = msg[j];
    seed2 = $urandom_range(1, 127);
    encode('h7B, seed2);
    run("watson", -1);
    chk("watson_lit_ptrn", int'(ptrn_idx), 8);
    chk("watson_lit_ack", first_ack, 83);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (mem[i] != ((i >= 10 && i < 10 + msg.len()) ? msg[i-10] : 8'h20)) bad++;
    chk("watson_lit_text", bad, 0);
    for (int i = 0; i < 64; i++) plain[i] = 8'h20;

    encode('h60, 1);
    mem[64] = 8'h00;
    run("zero_seed", -1);
    chk("zero_seed_lit_nm", int'(no_match), 1);
    chk("zero_seed_lit_ptrn", int'(ptrn_idx), 15);
    chk("zero_seed_lit_ack", first_ack, 10);

    encode('h00, 1);
    run("nomatch", -1);
    chk("nomatch_lit_nm", int'(no_match), 1);
    chk("nomatch_lit_ptrn", int'(ptrn_idx), 15);
    chk("nomatch_lit_ack", first_ack, 19);
    chk("nomatch_lit_writes", wr_count, 0);

    encode('h60, 1);
    mem[84] = mem[84] ^ 8'h80;
    run("parity", -1);
    chk("parity_lit_flag", int'(parity_err), 1);
    chk("parity_lit_addr20", int'(mem[20]), 'h20);

    encode('h60, 1);
    run("abort", 41);
    run("rerun", -1);
    chk("rerun_lit_ptrn", int'(ptrn_idx), 0);
    chk("rerun_lit_ack", first_ack, 75);
    chk("rerun_lit_text", count_not_space(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
